// File: rtl/axi_sram_slave_if.sv
// AXI4 bus bundle between an interconnect master port and the SRAM responder.
// IDs are 8 bits wide because the responder sits behind the interconnect.
interface axi_sram_slave_if;
    logic [7:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [7:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    logic [7:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [7:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 responder in front of a single-port word SRAM with one cycle of read
// latency. Handles INCR bursts of 1..16 beats one transaction at a time, with
// byte enables on writes and SLVERR for out-of-range or non-INCR beats.
module axi_sram_slave #(
    parameter int MEM_ADDR_W = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    axi_sram_slave_if.slave       io_axi,
    output logic                  o_sram_cs,
    output logic                  o_sram_we,
    output logic [3:0]            o_sram_bwe,
    output logic [MEM_ADDR_W-1:0] o_sram_addr,
    output logic [31:0]           o_sram_wdata,
    input  logic [31:0]           i_sram_rdata
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WRESP,
        RD_ADDR,
        RD_DATA
    } state_t;

    state_t                r_state;
    state_t                w_nextState;

    logic [7:0]            r_id;
    logic [MEM_ADDR_W-1:0] r_addr;
    logic [3:0]            r_len;
    logic [3:0]            r_beat;
    logic                  r_burstErr;
    logic                  r_rangeErr;
    logic                  r_wrErr;
    logic                  r_rdErr;
    logic                  r_rlast;
    logic                  r_rdFirst;
    logic [1:0]            r_rresp;
    logic [31:0]           r_rdata;

    logic [31:0]           w_reqAddr;
    logic [7:0]            w_reqId;
    logic [3:0]            w_reqLen;
    logic [1:0]            w_reqBurst;
    logic [MEM_ADDR_W:0]   w_wordIdx;
    logic                  w_beatErr;
    logic                  w_lastBeat;
    logic                  w_unusedBits;

    // AW wins whenever it is valid, so the request fields follow the same choice.
    assign w_reqAddr  = io_axi.awvalid ? io_axi.awaddr  : io_axi.araddr;
    assign w_reqId    = io_axi.awvalid ? io_axi.awid    : io_axi.arid;
    assign w_reqLen   = io_axi.awvalid ? io_axi.awlen   : io_axi.arlen;
    assign w_reqBurst = io_axi.awvalid ? io_axi.awburst : io_axi.arburst;

    // The extra top bit of the word index catches bursts running off the end of memory.
    assign w_wordIdx  = {1'b0, r_addr} + {{(MEM_ADDR_W-3){1'b0}}, r_beat};
    assign w_beatErr  = r_burstErr | r_rangeErr | w_wordIdx[MEM_ADDR_W];
    assign w_lastBeat = (r_beat == r_len);

    assign o_sram_addr = w_wordIdx[MEM_ADDR_W-1:0];

    assign io_axi.bid   = r_id;
    assign io_axi.rid   = r_id;
    assign io_axi.bresp = (r_state == WRESP && r_wrErr) ? RESP_SLVERR : RESP_OKAY;
    assign io_axi.rresp = (r_state == RD_DATA) ? r_rresp : RESP_OKAY;
    assign io_axi.rlast = (r_state == RD_DATA) && r_rlast;
    assign io_axi.rdata = (r_state == RD_DATA && r_rdFirst)
                        ? (r_rdErr ? 32'd0 : i_sram_rdata) : r_rdata;

    // Size is fixed at 32 bits and the low address bits do not select a word.
    assign w_unusedBits = ^{io_axi.awsize, io_axi.arsize, io_axi.awaddr[1:0], io_axi.araddr[1:0]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode plus the handshake and SRAM strobes for the current state.
    always_comb begin
        w_nextState    = r_state;
        io_axi.awready = 1'b0;
        io_axi.wready  = 1'b0;
        io_axi.bvalid  = 1'b0;
        io_axi.arready = 1'b0;
        io_axi.rvalid  = 1'b0;
        o_sram_cs      = 1'b0;
        o_sram_we      = 1'b0;
        o_sram_bwe     = 4'd0;
        o_sram_wdata   = 32'd0;
        case (r_state)
            IDLE: begin
                if (io_axi.awvalid) begin
                    io_axi.awready = 1'b1;
                    w_nextState    = WR;
                end else if (io_axi.arvalid) begin
                    io_axi.arready = 1'b1;
                    w_nextState    = RD_ADDR;
                end
            end
            WR: begin
                io_axi.wready = 1'b1;
                if (io_axi.wvalid) begin
                    if (!w_beatErr) begin
                        o_sram_cs    = 1'b1;
                        o_sram_we    = 1'b1;
                        o_sram_bwe   = io_axi.wstrb;
                        o_sram_wdata = io_axi.wdata;
                    end
                    if (io_axi.wlast) begin
                        w_nextState = WRESP;
                    end
                end
            end
            WRESP: begin
                io_axi.bvalid = 1'b1;
                if (io_axi.bready) begin
                    w_nextState = IDLE;
                end
            end
            RD_ADDR: begin
                o_sram_cs   = !w_beatErr;
                w_nextState = RD_DATA;
            end
            RD_DATA: begin
                io_axi.rvalid = 1'b1;
                if (io_axi.rready) begin
                    w_nextState = r_rlast ? IDLE : RD_ADDR;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Transaction context: request latch, beat counting, error tracking and read data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id       <= 8'd0;
            r_addr     <= '0;
            r_len      <= 4'd0;
            r_beat     <= 4'd0;
            r_burstErr <= 1'b0;
            r_rangeErr <= 1'b0;
            r_wrErr    <= 1'b0;
            r_rdErr    <= 1'b0;
            r_rlast    <= 1'b0;
            r_rdFirst  <= 1'b0;
            r_rresp    <= RESP_OKAY;
            r_rdata    <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (io_axi.awvalid || io_axi.arvalid) begin
                        r_id       <= w_reqId;
                        r_addr     <= w_reqAddr[MEM_ADDR_W+1:2];
                        r_len      <= w_reqLen;
                        r_beat     <= 4'd0;
                        r_burstErr <= (w_reqBurst != BURST_INCR);
                        r_rangeErr <= |w_reqAddr[31:MEM_ADDR_W+2];
                        r_wrErr    <= 1'b0;
                    end
                end
                WR: begin
                    if (io_axi.wvalid) begin
                        r_beat <= r_beat + 4'd1;
                        if (w_beatErr || (io_axi.wlast != w_lastBeat)) begin
                            r_wrErr <= 1'b1;
                        end
                    end
                end
                RD_ADDR: begin
                    r_rresp   <= w_beatErr ? RESP_SLVERR : RESP_OKAY;
                    r_rlast   <= w_lastBeat;
                    r_rdErr   <= w_beatErr;
                    r_rdFirst <= 1'b1;
                end
                RD_DATA: begin
                    if (r_rdFirst) begin
                        r_rdata <= r_rdErr ? 32'd0 : i_sram_rdata;
                    end
                    r_rdFirst <= 1'b0;
                    if (io_axi.rready && !r_rlast) begin
                        r_beat <= r_beat + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: stimulus pushes expected B/R responses,
// a negedge monitor pops and compares whenever a handshake is about to occur.
module tb_axi_sram_slave;
    localparam int         MEM_ADDR_W = 14;
    localparam int         TIMEOUT    = 200;
    localparam logic [1:0] OKAY       = 2'b00;
    localparam logic [1:0] SLVERR     = 2'b10;
    localparam logic [1:0] INCR       = 2'b01;
    localparam logic [1:0] FIXED      = 2'b00;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rBeat_t;

    typedef struct packed {
        logic [7:0] id;
        logic [1:0] resp;
    } bResp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  sramCs;
    logic                  sramWe;
    logic [3:0]            sramBwe;
    logic [MEM_ADDR_W-1:0] sramAddr;
    logic [31:0]           sramWdata;
    logic [31:0]           sramRdata = 32'd0;
    logic [31:0]           mem [0:(1<<MEM_ADDR_W)-1];

    int     testsRun    = 0;
    int     testsFailed = 0;
    int     stallChecks = 0;
    int     csCount     = 0;
    logic   stallPending = 1'b0;
    rBeat_t stallHeld;
    rBeat_t rExpQ[$];
    bResp_t bExpQ[$];

    axi_sram_slave_if bus();

    axi_sram_slave #(.MEM_ADDR_W(MEM_ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .io_axi       (bus),
        .o_sram_cs    (sramCs),
        .o_sram_we    (sramWe),
        .o_sram_bwe   (sramBwe),
        .o_sram_addr  (sramAddr),
        .o_sram_wdata (sramWdata),
        .i_sram_rdata (sramRdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port SRAM with byte writes and a registered read port.
    always @(posedge clk) begin
        if (sramCs) begin
            csCount <= csCount + 1;
            if (sramWe) begin
                for (int b = 0; b < 4; b++) begin
                    if (sramBwe[b]) mem[sramAddr][8*b +: 8] <= sramWdata[8*b +: 8];
                end
            end else begin
                sramRdata <= mem[sramAddr];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: compare every B and R handshake against the scoreboard, and
    // confirm R outputs hold steady while the master stalls.
    always @(negedge clk) begin : monitor
        rBeat_t got;
        rBeat_t exp;
        bResp_t bExp;
        if (rst) begin
            stallPending = 1'b0;
        end else begin
            if (bus.bvalid && bus.bready) begin
                checkOutput("B expected", bExpQ.size() > 0, 1);
                if (bExpQ.size() > 0) begin
                    bExp = bExpQ.pop_front();
                    checkOutput("BID", bus.bid, bExp.id);
                    checkOutput("BRESP", bus.bresp, bExp.resp);
                end
            end
            if (bus.rvalid) begin
                got = {bus.rid, bus.rdata, bus.rresp, bus.rlast};
                if (stallPending) begin
                    stallChecks++;
                    checkOutput("R stable during stall", got, stallHeld);
                end
                if (bus.rready) begin
                    stallPending = 1'b0;
                    checkOutput("R expected", rExpQ.size() > 0, 1);
                    if (rExpQ.size() > 0) begin
                        exp = rExpQ.pop_front();
                        checkOutput("R beat {id,data,resp,last}", got, exp);
                    end
                end else begin
                    stallPending = 1'b1;
                    stallHeld    = got;
                end
            end else begin
                stallPending = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic awPhase(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst);
        bit ok = 1'b0;
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = 3'd2; bus.awburst = burst;
        bus.awvalid = 1'b1;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if (bus.awready) begin ok = 1'b1; break; end
        end
        checkOutput("AW handshake", ok, 1);
        tick();
        bus.awvalid = 1'b0;
    endtask

    task automatic wBeat(input logic [31:0] data, input logic [3:0] strb, input logic last);
        bit ok = 1'b0;
        bus.wdata = data; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if (bus.wready) begin ok = 1'b1; break; end
        end
        checkOutput("W handshake", ok, 1);
        tick();
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
    endtask

    task automatic arPhase(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst);
        bit ok = 1'b0;
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = 3'd2; bus.arburst = burst;
        bus.arvalid = 1'b1;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if (bus.arready) begin ok = 1'b1; break; end
        end
        checkOutput("AR handshake", ok, 1);
        tick();
        bus.arvalid = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            if (bExpQ.size() == 0 && rExpQ.size() == 0) begin ok = 1'b1; break; end
            tick();
        end
        checkOutput(name, ok, 1);
        tick();
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " READY/VALID/RLAST"},
                    {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast}, 0);
        checkOutput({tag, " BRESP/RRESP"}, {bus.bresp, bus.rresp}, 0);
        checkOutput({tag, " BID/RID"}, {bus.bid, bus.rid}, 0);
        checkOutput({tag, " RDATA"}, bus.rdata, 0);
        checkOutput({tag, " SRAM cs/we/bwe"}, {sramCs, sramWe, sramBwe}, 0);
    endtask

    task automatic applyStimulus();
        bit ok;
        int csBefore;

        // 1: single write then read of the same word, with latency checks
        bExpQ.push_back('{8'h12, OKAY});
        awPhase(8'h12, 32'h40, 4'd0, INCR);
        wBeat(32'hDEADBEEF, 4'hF, 1'b1);
        checkOutput("BVALID cycle after last W", bus.bvalid, 1);
        waitDrain("t1 write drained");
        rExpQ.push_back('{8'h34, 32'hDEADBEEF, OKAY, 1'b1});
        arPhase(8'h34, 32'h40, 4'd0, INCR);
        checkOutput("RVALID low 1 cycle after AR", bus.rvalid, 0);
        tick();
        checkOutput("RVALID high before 2nd edge after AR", bus.rvalid, 1);
        waitDrain("t1 read drained");

        // 2: byte-enable merge
        bExpQ.push_back('{8'h21, OKAY});
        awPhase(8'h21, 32'h80, 4'd0, INCR);
        wBeat(32'hAABBCCDD, 4'hF, 1'b1);
        bExpQ.push_back('{8'h22, OKAY});
        awPhase(8'h22, 32'h80, 4'd0, INCR);
        wBeat(32'h00001100, 4'b0010, 1'b1);
        rExpQ.push_back('{8'h23, 32'hAABB11DD, OKAY, 1'b1});
        arPhase(8'h23, 32'h80, 4'd0, INCR);
        waitDrain("t2 drained");

        // 3: 4-beat burst, readback with RREADY stalls
        bExpQ.push_back('{8'h31, OKAY});
        awPhase(8'h31, 32'h100, 4'd3, INCR);
        wBeat(32'd1, 4'hF, 1'b0);
        wBeat(32'd2, 4'hF, 1'b0);
        wBeat(32'd3, 4'hF, 1'b0);
        wBeat(32'd4, 4'hF, 1'b1);
        waitDrain("t3 write drained");
        rExpQ.push_back('{8'h33, 32'd1, OKAY, 1'b0});
        rExpQ.push_back('{8'h33, 32'd2, OKAY, 1'b0});
        rExpQ.push_back('{8'h33, 32'd3, OKAY, 1'b0});
        rExpQ.push_back('{8'h33, 32'd4, OKAY, 1'b1});
        bus.rready = 1'b0;
        arPhase(8'h33, 32'h100, 4'd3, INCR);
        ok = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            if (rExpQ.size() == 0) begin ok = 1'b1; break; end
            bus.rready = (i % 3 == 2);
            tick();
        end
        bus.rready = 1'b1;
        checkOutput("t3 stalled burst drained", ok, 1);
        checkOutput("t3 stalls observed", stallChecks > 0, 1);
        tick();

        // 3b: WLAST early on a 2-beat write gives a sticky SLVERR
        bExpQ.push_back('{8'h35, SLVERR});
        awPhase(8'h35, 32'h500, 4'd1, INCR);
        wBeat(32'h11111111, 4'hF, 1'b1);
        waitDrain("t3b drained");

        // 4: burst wrapping past the top word, then out-of-range accesses
        bExpQ.push_back('{8'h40, OKAY});
        awPhase(8'h40, 32'h0000FFFC, 4'd0, INCR);
        wBeat(32'h12345678, 4'hF, 1'b1);
        waitDrain("t4 write drained");
        rExpQ.push_back('{8'h41, 32'h12345678, OKAY, 1'b0});
        rExpQ.push_back('{8'h41, 32'h00000000, SLVERR, 1'b1});
        arPhase(8'h41, 32'h0000FFFC, 4'd1, INCR);
        waitDrain("t4 wrap read drained");
        csBefore = csCount;
        rExpQ.push_back('{8'h42, 32'h00000000, SLVERR, 1'b1});
        arPhase(8'h42, 32'h80000000, 4'd0, INCR);
        waitDrain("t4 range read drained");
        bExpQ.push_back('{8'h43, SLVERR});
        awPhase(8'h43, 32'h80000000, 4'd0, INCR);
        wBeat(32'hFFFFFFFF, 4'hF, 1'b1);
        waitDrain("t4 range write drained");
        checkOutput("t4 no sram_cs on range errors", csCount - csBefore, 0);

        // 5: simultaneous AW and AR, AW first
        bExpQ.push_back('{8'h51, OKAY});
        rExpQ.push_back('{8'h52, 32'hCAFEF00D, OKAY, 1'b1});
        bus.awid = 8'h51; bus.awaddr = 32'h200; bus.awlen = 4'd0; bus.awsize = 3'd2; bus.awburst = INCR;
        bus.arid = 8'h52; bus.araddr = 32'h200; bus.arlen = 4'd0; bus.arsize = 3'd2; bus.arburst = INCR;
        bus.awvalid = 1'b1;
        bus.arvalid = 1'b1;
        @(negedge clk);
        checkOutput("t5 AWREADY on collision", bus.awready, 1);
        checkOutput("t5 ARREADY on collision", bus.arready, 0);
        tick();
        bus.awvalid = 1'b0;
        wBeat(32'hCAFEF00D, 4'hF, 1'b1);
        checkOutput("t5 ARREADY held off in WRESP", bus.arready, 0);
        arPhase(8'h52, 32'h200, 4'd0, INCR);
        waitDrain("t5 drained");

        // 5b: FIXED burst is rejected
        rExpQ.push_back('{8'h53, 32'h00000000, SLVERR, 1'b1});
        arPhase(8'h53, 32'h40, 4'd0, FIXED);
        waitDrain("t5b drained");

        // 6: reset in the middle of a read burst, then a normal transaction
        bus.rready = 1'b0;
        arPhase(8'h61, 32'h40, 4'd3, INCR);
        ok = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            if (bus.rvalid) begin ok = 1'b1; break; end
            tick();
        end
        checkOutput("t6 RVALID before reset", ok, 1);
        rst = 1'b1;
        tick();
        checkResetState("t6 after reset");
        rst = 1'b0;
        bus.rready = 1'b1;
        repeat (3) tick();
        checkOutput("t6 dropped burst stays silent", bus.rvalid, 0);
        bExpQ.push_back('{8'h62, OKAY});
        awPhase(8'h62, 32'h300, 4'd0, INCR);
        wBeat(32'h5A5A5A5A, 4'hF, 1'b1);
        rExpQ.push_back('{8'h63, 32'h5A5A5A5A, OKAY, 1'b1});
        arPhase(8'h63, 32'h300, 4'd0, INCR);
        waitDrain("t6 post-reset drained");
    endtask

    // Hard stop in case something blocks forever.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, %0d tests run", testsRun);
        $fatal(1, "[TB] watchdog");
    end

    // Main sequence: reset, reset-state checks, then the directed tests.
    initial begin
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b1;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        checkResetState("reset");
        rst = 1'b0;
        tick();
        applyStimulus();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
